pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding muxes.
- Freezes the whole pipeline while data memory has not acknowledged a request, with a timeout into a sticky error state.

---
 rtl/pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [15:0] TO = 16'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_nxt;
    logic        r_mem_err;
    logic        w_err_nxt;

    logic w_freeze;
    logic w_load_use;
    logic w_use_run;

    assign w_freeze   = mem_req && !mem_ack;
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0)
                     && ((ex_rd == id_rs) || (ex_rd == id_rt));

    // RUN rules apply in RUN without a freeze and in the release cycle
    assign w_use_run = !rst
                    && (((r_state == S_RUN) && !w_freeze)
                     || ((r_state == S_WAIT) && mem_ack));

    assign state   = r_state;
    assign mem_err = r_mem_err;

    // State, wait counter and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 16'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_err_nxt;
        end
    end

    // Next-state: freeze on unacked memory, time out into sticky ERR
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_mem_err;
        unique case (r_state)
            S_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = 16'd1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = 16'd0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 16'd1;
                    if (r_wait_cnt == TO) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                w_state_nxt = S_ERR;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = 16'd0;
            end
        endcase
    end

    // Enables and flushes; branch squashes ID, so it beats load-use
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (w_use_run) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Operand forwarding, EX/MEM ahead of MEM/WB, r0 never forwarded
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs))
                fwd_a = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs))
                fwd_a = 2'b01;
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt))
                fwd_b = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt))
                fwd_b = 2'b01;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    // Saturating counts of stalled-PC cycles and ID/EX bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (id_ex_flush && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Built with MEM_TIMEOUT=4; PIPE_PERF_CNT_EN changes the counter expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        ex_mem_read, ex_branch_taken;
    logic        mem_reg_write, wb_reg_write, mem_req, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_err;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;

    wire [6:0] ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                      mem_wb_en, if_id_flush, id_ex_flush};

    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1111100;
    localparam logic [6:0] C_LU   = 7'b0011101;
    localparam logic [6:0] C_BR   = 7'b1111111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
        mem_reg_write = 0; wb_reg_write = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        mem_rd = 3; ex_rs = 3; mem_reg_write = 1;
        step();
        step();
        tests++;
        if (ctl !== C_ZERO) begin
            fails++;
            $display("FAIL rst_ctl got %b want %b", ctl, C_ZERO);
        end
        tests++;
        if (fwd_a !== 2'b00) begin
            fails++;
            $display("FAIL rst_fwd got %b want 00", fwd_a);
        end
        tests++;
        if (state !== 2'd0 || mem_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_state got %0d/%b want 0/0", state, mem_err);
        end
        tests++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            fails++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0",
                     stall_cycles, flush_count);
        end
        rst = 1'b0;
        idle();
        step();
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL run_idle got %b want %b", ctl, C_RUN);
        end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1; ex_rd = 5; id_rs = 5;
        #1;
        tests++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL lu_rs got %b want %b", ctl, C_LU);
        end
        step();
        ex_mem_read = 0;
        #1;
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL lu_clear got %b want %b", ctl, C_RUN);
        end
        step();
        ex_mem_read = 1; ex_rd = 9; id_rs = 1; id_rt = 9;
        #1;
        tests++;
        if (ctl !== C_LU) begin
            fails++;
            $display("FAIL lu_rt got %b want %b", ctl, C_LU);
        end
        step();
        ex_rd = 0; id_rs = 0; id_rt = 0;
        #1;
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL lu_r0 got %b want %b", ctl, C_RUN);
        end
        step();
        idle();
    endtask

    task automatic test_branch();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs = 5;
        #1;
        tests++;
        if (ctl !== C_BR) begin
            fails++;
            $display("FAIL br_lu got %b want %b", ctl, C_BR);
        end
        step();
        ex_mem_read = 0;
        #1;
        tests++;
        if (ctl !== C_BR) begin
            fails++;
            $display("FAIL br_only got %b want %b", ctl, C_BR);
        end
        step();
        idle();
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ack = 1;
        #1;
        tests++;
        if (ctl !== C_RUN) begin
            fails++;
            $display("FAIL mem_fast got %b want %b", ctl, C_RUN);
        end
        step();
        tests++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL mem_fast_st got %0d want 0", state);
        end
        mem_ack = 0;
        #1;
        tests++;
        if (ctl !== C_ZERO) begin
            fails++;
            $display("FAIL mem_frz got %b want %b", ctl, C_ZERO);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            ex_branch_taken = (i == 2);
            #1;
            tests++;
            if (state !== 2'd1 || ctl !== C_ZERO) begin
                fails++;
                $display("FAIL mem_wait%0d got %0d/%b want 1/%b",
                         i, state, ctl, C_ZERO);
            end
        end
        mem_ack = 1;
        #1;
        tests++;
        if (state !== 2'd1 || ctl !== C_BR) begin
            fails++;
            $display("FAIL mem_rel got %0d/%b want 1/%b", state, ctl, C_BR);
        end
        step();
        idle();
        #1;
        tests++;
        if (state !== 2'd0 || ctl !== C_RUN) begin
            fails++;
            $display("FAIL mem_after got %0d/%b want 0/%b", state, ctl, C_RUN);
        end
    endtask

    task automatic test_timeout();
        mem_req = 1; mem_ack = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if (state !== 2'd1 || mem_err !== 1'b0) begin
                fails++;
                $display("FAIL to_wait%0d got %0d/%b want 1/0",
                         i, state, mem_err);
            end
        end
        step();
        tests++;
        if (state !== 2'd2 || mem_err !== 1'b1 || ctl !== C_ZERO) begin
            fails++;
            $display("FAIL to_err got %0d/%b/%b want 2/1/%b",
                     state, mem_err, ctl, C_ZERO);
        end
        mem_ack = 1; ex_branch_taken = 1;
        step();
        step();
        tests++;
        if (state !== 2'd2 || mem_err !== 1'b1 || ctl !== C_ZERO) begin
            fails++;
            $display("FAIL to_sticky got %0d/%b/%b want 2/1/%b",
                     state, mem_err, ctl, C_ZERO);
        end
        rst = 1;
        step();
        rst = 0;
        idle();
        #1;
        tests++;
        if (state !== 2'd0 || mem_err !== 1'b0) begin
            fails++;
            $display("FAIL to_rst got %0d/%b want 0/0", state, mem_err);
        end
    endtask

    task automatic test_forward();
        mem_rd = 7; wb_rd = 7; ex_rs = 7; ex_rt = 7;
        mem_reg_write = 1; wb_reg_write = 1;
        #1;
        tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mem got %b/%b want 10/10", fwd_a, fwd_b);
        end
        mem_reg_write = 0;
        #1;
        tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            fails++;
            $display("FAIL fwd_wb got %b/%b want 01/01", fwd_a, fwd_b);
        end
        ex_rs = 0;
        #1;
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
            fails++;
            $display("FAIL fwd_r0 got %b/%b want 00/01", fwd_a, fwd_b);
        end
        mem_reg_write = 1; mem_rd = 0; ex_rs = 0; ex_rt = 0; wb_rd = 0;
        #1;
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL fwd_rd0 got %b/%b want 00/00", fwd_a, fwd_b);
        end
        mem_rd = 4; ex_rt = 4; wb_rd = 6; ex_rs = 6;
        #1;
        tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mix got %b/%b want 01/10", fwd_a, fwd_b);
        end
        step();
        idle();
    endtask

    task automatic test_perf();
        logic [15:0] exp_s;
        logic [15:0] exp_f;
`ifdef PIPE_PERF_CNT_EN
        exp_s = 16'd2;
        exp_f = 16'd3;
`else
        exp_s = 16'd0;
        exp_f = 16'd0;
`endif
        rst = 1;
        idle();
        step();
        rst = 0;
        ex_mem_read = 1; ex_rd = 5; id_rs = 5;
        step();
        idle();
        step();
        ex_mem_read = 1; ex_rd = 5; id_rt = 5;
        step();
        idle();
        ex_branch_taken = 1;
        step();
        idle();
        #1;
        tests++;
        if (stall_cycles !== exp_s) begin
            fails++;
            $display("FAIL perf_stall got %0d want %0d", stall_cycles, exp_s);
        end
        tests++;
        if (flush_count !== exp_f) begin
            fails++;
            $display("FAIL perf_flush got %0d want %0d", flush_count, exp_f);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_forward();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
